// File: rtl/half_sub_data.sv
// Registered multi-lane half subtractor with a saturating count of accepted borrow bits.
// Outputs update one cycle after a valid input. In-valid-low cycles keep the previous result.
module half_sub_data #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X_in,
  input  logic [WIDTH-1:0] Y_in,
  input  logic             count_clear,
  output logic [WIDTH-1:0] difference,
  output logic [WIDTH-1:0] barrow,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_count
);

  localparam int POP_W = $clog2(WIDTH + 1);
  // One spare bit so that count + popcount can never overflow before the saturation compare.
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [WIDTH-1:0] borrow_bits;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] next_count;

  assign borrow_bits = ~X_in & Y_in;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(borrow_bits[i]);
    end
  end

  assign sum        = SUM_W'(borrow_count) + SUM_W'(pop);
  assign next_count = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      difference   <= '0;
      barrow       <= '0;
      out_valid    <= 1'b0;
      borrow_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        difference <= X_in ^ Y_in;
        barrow     <= borrow_bits;
      end
      // A clear in the same cycle as a valid input discards that cycle's borrows.
      if (count_clear) begin
        borrow_count <= '0;
      end else if (in_valid) begin
        borrow_count <= next_count;
      end
    end
  end

endmodule

// File: tb/tb_half_sub_data.sv
// Bench for half_sub_data: a 4-lane instance and a 1-lane instance with a 2-bit counter share stimulus.
// Expected values come from a behavioural model using plain arithmetic and saturation by min().
module tb_half_sub_data;

  logic       clk = 1'b0;
  logic       rst, in_valid, count_clear;
  logic [3:0] x_a, y_a;

  logic [3:0]  diff_a, bar_a;
  logic        ov_a;
  logic [15:0] cnt_a;
  logic [0:0]  diff_b, bar_b;
  logic        ov_b;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_diff_a = '0, m_bar_a = '0;
  logic       m_diff_b = 1'b0, m_bar_b = 1'b0, m_ov = 1'b0;
  int         m_cnt_a = 0, m_cnt_b = 0;

  always #5 clk = ~clk;

  half_sub_data #(.WIDTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .X_in(x_a), .Y_in(y_a),
    .count_clear(count_clear), .difference(diff_a), .barrow(bar_a),
    .out_valid(ov_a), .borrow_count(cnt_a)
  );

  half_sub_data #(.WIDTH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .X_in(x_a[0:0]), .Y_in(y_a[0:0]),
    .count_clear(count_clear), .difference(diff_b), .barrow(bar_b),
    .out_valid(ov_b), .borrow_count(cnt_b)
  );

  function automatic int sat_add(input int cur, input int add, input int max);
    return (cur + add > max) ? max : cur + add;
  endfunction

  // Drive one cycle, then advance the model to what the outputs should hold after the edge.
  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y,
                       input logic clr, input logic r);
    int pop_a, pop_b;
    @(negedge clk);
    in_valid = v; x_a = x; y_a = y; count_clear = clr; rst = r;
    @(posedge clk);
    #1;
    pop_a = $countones(~x & y);
    pop_b = (x[0] == 1'b0 && y[0] == 1'b1) ? 1 : 0;
    if (r) begin
      m_diff_a = '0; m_bar_a = '0; m_diff_b = 1'b0; m_bar_b = 1'b0;
      m_ov = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      m_ov = v;
      if (v) begin
        m_diff_a = x ^ y;  m_bar_a = ~x & y;
        m_diff_b = x[0] ^ y[0]; m_bar_b = ~x[0] & y[0];
      end
      if (clr) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else if (v) begin
        m_cnt_a = sat_add(m_cnt_a, pop_a, 65535);
        m_cnt_b = sat_add(m_cnt_b, pop_b, 3);
      end
    end
  endtask

  task automatic test_reset;
    drive(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1);
    drive(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1);
    total++;
    if ({diff_a, bar_a, ov_a, cnt_a} !== 25'd0) begin
      bad++; $display("FAIL reset_a got %h required 0", {diff_a, bar_a, ov_a, cnt_a});
    end
    total++;
    if ({diff_b, bar_b, ov_b, cnt_b} !== 5'd0) begin
      bad++; $display("FAIL reset_b got %h required 0", {diff_b, bar_b, ov_b, cnt_b});
    end
  endtask

  task automatic test_truth_table;
    logic [3:0] xs [4] = '{4'h0, 4'h0, 4'h1, 4'h1};
    logic [3:0] ys [4] = '{4'h0, 4'h1, 4'h0, 4'h1};
    logic [1:0] want_b [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], ys[i], 1'b0, 1'b0);
      total++;
      if ({diff_b, bar_b, ov_b} !== {want_b[i], 1'b1}) begin
        bad++; $display("FAIL truth_b[%0d] got %b required %b", i, {diff_b, bar_b, ov_b}, {want_b[i], 1'b1});
      end
      total++;
      if (cnt_b !== 2'(m_cnt_b) || cnt_a !== 16'(m_cnt_a)) begin
        bad++; $display("FAIL truth_cnt[%0d] got a=%0d b=%0d required a=%0d b=%0d", i, cnt_a, cnt_b, m_cnt_a, m_cnt_b);
      end
    end
  endtask

  task automatic test_hold;
    drive(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0);
    drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0101, 4'b1010, 1'b0, 1'b0);
    total++;
    if ({diff_b, bar_b, ov_b} !== 3'b110) begin
      bad++; $display("FAIL hold_b got %b required 110", {diff_b, bar_b, ov_b});
    end
    total++;
    if ({diff_a, bar_a, ov_a, cnt_a} !== {m_diff_a, m_bar_a, m_ov, 16'(m_cnt_a)}) begin
      bad++; $display("FAIL hold_a got %h required %h", {diff_a, bar_a, ov_a, cnt_a}, {m_diff_a, m_bar_a, m_ov, 16'(m_cnt_a)});
    end
  endtask

  task automatic test_clear_wins;
    int prev;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    prev = m_cnt_a;
    drive(1'b1, 4'b0000, 4'b1011, 1'b0, 1'b0);
    total++;
    if ({diff_a, bar_a, cnt_a} !== {4'b1011, 4'b1011, 16'(prev + 3)}) begin
      bad++; $display("FAIL count_plus3 got diff=%b bar=%b cnt=%0d required 1011 1011 %0d", diff_a, bar_a, cnt_a, prev + 3);
    end
    drive(1'b1, 4'b0000, 4'b1011, 1'b1, 1'b0);
    total++;
    if ({diff_a, bar_a, ov_a, cnt_a, cnt_b} !== {4'b1011, 4'b1011, 1'b1, 16'd0, 2'd0}) begin
      bad++; $display("FAIL clear_wins got diff=%b bar=%b ov=%b cnt_a=%0d cnt_b=%0d required 1011 1011 1 0 0", diff_a, bar_a, ov_a, cnt_a, cnt_b);
    end
  endtask

  task automatic test_saturation;
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0);
      total++;
      if (cnt_b !== 2'(m_cnt_b)) begin
        bad++; $display("FAIL sat_step[%0d] got %0d required %0d", i, cnt_b, m_cnt_b);
      end
    end
    total++;
    if (cnt_b !== 2'd3 || cnt_a !== 16'd5) begin
      bad++; $display("FAIL sat_final got b=%0d a=%0d required b=3 a=5", cnt_b, cnt_a);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0);
    drive(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1);
    total++;
    if ({diff_a, bar_a, ov_a, cnt_a, diff_b, bar_b, ov_b, cnt_b} !== 30'd0) begin
      bad++; $display("FAIL reset_mid got a=%h b=%h required 0", {diff_a, bar_a, ov_a, cnt_a}, {diff_b, bar_b, ov_b, cnt_b});
    end
    drive(1'b1, 4'b0010, 4'b0111, 1'b0, 1'b0);
    total++;
    if ({diff_a, bar_a, ov_a, cnt_a} !== {4'b0101, 4'b0101, 1'b1, 16'd2}) begin
      bad++; $display("FAIL first_after_reset got %h required diff=0101 bar=0101 ov=1 cnt=2", {diff_a, bar_a, ov_a, cnt_a});
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(3) != 0), 4'($urandom), 4'($urandom),
            ($urandom_range(7) == 0), ($urandom_range(40) == 0));
      total++;
      if ({diff_a, bar_a, ov_a, cnt_a} !== {m_diff_a, m_bar_a, m_ov, 16'(m_cnt_a)}) begin
        bad++; $display("FAIL rand_a[%0d] got %h required %h", i, {diff_a, bar_a, ov_a, cnt_a}, {m_diff_a, m_bar_a, m_ov, 16'(m_cnt_a)});
      end
      total++;
      if ({diff_b, bar_b, ov_b, cnt_b} !== {m_diff_b, m_bar_b, m_ov, 2'(m_cnt_b)}) begin
        bad++; $display("FAIL rand_b[%0d] got %b required %b", i, {diff_b, bar_b, ov_b, cnt_b}, {m_diff_b, m_bar_b, m_ov, 2'(m_cnt_b)});
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; count_clear = 1'b0; x_a = '0; y_a = '0;
    test_reset();
    test_truth_table();
    test_hold();
    test_clear_wins();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/half_sub_data.md
HALF_SUB_DATA -- requirements
Module: half_sub_data

Interface
REQ-001 Parameter WIDTH, default 1: number of independent half-subtractor lanes.
REQ-002 Parameter CNT_W, default 16: width of the borrow event counter.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid  input  1: X_in/Y_in qualify this cycle.
REQ-006 Port X_in  input  WIDTH: minuend bits, one per lane.
REQ-007 Port Y_in  input  WIDTH: subtrahend bits, one per lane.
REQ-008 Port count_clear  input  1: synchronous clear of borrow_count.
REQ-009 Port difference  output  WIDTH: registered X_in XOR Y_in per lane.
REQ-010 Port barrow  output  WIDTH: registered borrow per lane, (NOT X_in) AND Y_in.
REQ-011 Port out_valid  output  1: difference/barrow hold a result captured from a valid input.
REQ-012 Port borrow_count  output  CNT_W: saturating count of asserted borrow bits accepted since reset/clear.

Function
REQ-013 On a clock edge with in_valid=1 and rst=0, difference[i] SHALL load X_in[i] ^ Y_in[i] for every lane i.
REQ-014 On the same edge, barrow[i] SHALL load ~X_in[i] & Y_in[i].
REQ-015 Latency SHALL be exactly 1 cycle from input sample to registered output; no combinational path from inputs to outputs.
REQ-016 out_valid SHALL be a registered copy of in_valid (1 on the cycle after a valid input, else 0).
REQ-017 With in_valid=0, difference and barrow SHALL hold their previous values; out_valid SHALL be 0.
REQ-018 Lanes SHALL be fully independent; no borrow propagates between lanes.
REQ-019 On a valid input, borrow_count SHALL increase by the number of lanes with ~X_in & Y_in = 1 (population count), in the same edge as the outputs update.
REQ-020 borrow_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 count_clear=1 SHALL set borrow_count to 0 on the edge; if in_valid=1 in the same cycle, the clear SHALL win and that cycle's borrows SHALL NOT be counted; difference/barrow/out_valid still update normally.
REQ-022 Inputs SHALL be treated as unsigned single bits per lane; no X/Z resolution beyond standard RTL semantics.

Reset
REQ-023 When rst=1 at a rising edge, difference, barrow, borrow_count SHALL become all zeros and out_valid SHALL become 0, regardless of in_valid or count_clear.
REQ-024 Reset SHALL take priority over all other inputs; a valid input coincident with reset SHALL be discarded and not counted.
REQ-025 The first result after reset release SHALL appear one cycle after the first edge with rst=0 and in_valid=1.

Verification
REQ-026 WIDTH=1, in_valid=1, X_in=0,Y_in=0 -> next cycle difference=0, barrow=0, out_valid=1, borrow_count unchanged.
REQ-027 X_in=0,Y_in=1 -> difference=1, barrow=1, borrow_count +1; X_in=1,Y_in=0 -> difference=1, barrow=0; X_in=1,Y_in=1 -> difference=0, barrow=0 (each applied for 10 time units / one or more cycles).
REQ-028 Drop in_valid after X_in=0,Y_in=1 then change inputs -> difference=1, barrow=1 held, out_valid=0, count unchanged.
REQ-029 Assert rst mid-sequence with in_valid=1, X_in=0,Y_in=1 -> next cycle all outputs 0, borrow_count=0, out_valid=0.
REQ-030 WIDTH=4, X_in=4'b0000, Y_in=4'b1011 -> difference=4'b1011, barrow=4'b1011, borrow_count +3; same-cycle count_clear=1 -> borrow_count=0.
REQ-031 CNT_W=2, repeat X_in=0,Y_in=1 five times -> borrow_count stops at 3 with no wrap.
